// File: rtl/wb_dst_pipe_if.sv
// Bundle between the decode-stage logic and the write-destination pipeline.
// The two counter outputs exist only when WB_COUNT_EN is defined.
interface wb_dst_pipe_if #(
  parameter int AW = 5
);
  logic          D_valid;
  logic [5:0]    D_op;
  logic [AW-1:0] D_rt;
  logic [AW-1:0] D_rd;
  logic [AW-1:0] D_srcA;
  logic [AW-1:0] D_srcB;
  logic          stall_in;
  logic          flush_E;
  logic          ld_stall;
  logic [AW-1:0] E_dst;
  logic [AW-1:0] M_dst;
  logic [AW-1:0] W_dst;
  logic          E_wen;
  logic          M_wen;
  logic          W_wen;
  logic          rf_we;
  logic [AW-1:0] rf_waddr;
`ifdef WB_COUNT_EN
  logic [31:0]   wb_count;
  logic [31:0]   bubble_count;
`endif

  // Decode-stage side: supplies the instruction fields and pipeline controls.
  modport master (
    output D_valid, D_op, D_rt, D_rd, D_srcA, D_srcB, stall_in, flush_E,
    input  ld_stall, E_dst, M_dst, W_dst, E_wen, M_wen, W_wen, rf_we, rf_waddr
`ifdef WB_COUNT_EN
    , input wb_count, bubble_count
`endif
  );

  // Pipeline side: consumes the fields and reports stage destinations.
  modport slave (
    input  D_valid, D_op, D_rt, D_rd, D_srcA, D_srcB, stall_in, flush_E,
    output ld_stall, E_dst, M_dst, W_dst, E_wen, M_wen, W_wen, rf_we, rf_waddr
`ifdef WB_COUNT_EN
    , output wb_count, bubble_count
`endif
  );
endinterface

// File: rtl/wb_dst_pipe.sv
// Destination-register pipeline: decodes the write target of the D-stage
// instruction, carries it through E/M/W and drives the register-file write
// port at W. Also raises the load-use stall against the D-stage sources.
// Optional macro WB_COUNT_EN adds write-back and bubble counters.
module wb_dst_pipe #(
  parameter int RA_REG = 31,
  parameter int AW     = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  wb_dst_pipe_if.slave  bus
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;

  // E carries the load flag for hazard detection; M and W only need the write.
  typedef struct packed {
    logic          wen;
    logic          load;
    logic [AW-1:0] dst;
  } e_stage_t;

  typedef struct packed {
    logic          wen;
    logic [AW-1:0] dst;
  } wb_stage_t;

  logic [AW-1:0] dst_raw;
  logic          load_raw;
  e_stage_t      d_dec;
  e_stage_t      e_q;
  wb_stage_t     m_q;
  wb_stage_t     w_q;
  logic          bubble;

  // Opcode to destination-register selection.
  always_comb begin
    // NOTE: defaults before the case cover every path, so no latch is inferred.
    dst_raw  = '0;
    load_raw = 1'b0;
    case (bus.D_op)
      OP_RTYPE: dst_raw = bus.D_rd;
      OP_LW: begin
        dst_raw  = bus.D_rt;
        load_raw = 1'b1;
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_LUI: dst_raw = bus.D_rt;
      OP_JAL:  dst_raw = AW'(RA_REG);
      default: ;
    endcase
  end

  // A write to $0 or from an empty slot is dropped here so it never travels.
  always_comb begin
    d_dec.wen  = bus.D_valid & (dst_raw != '0);
    d_dec.dst  = d_dec.wen ? dst_raw : '0;
    d_dec.load = d_dec.wen & load_raw;
  end

  assign bus.ld_stall = bus.D_valid & e_q.load & e_q.wen &
                        ((e_q.dst == bus.D_srcA) | (e_q.dst == bus.D_srcB));

  // Any stall source inserts one bubble; coincident sources do not stack.
  assign bubble = bus.stall_in | bus.flush_E | bus.ld_stall;

  // Stage registers: E takes D or a bubble, M and W always advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_q <= '0;
      m_q <= '0;
      w_q <= '0;
    end else begin
      // NOTE: non-blocking updates let M and W read the previous E and M values.
      e_q <= bubble ? e_stage_t'('0) : d_dec;
      m_q <= '{wen: e_q.wen, dst: e_q.dst};
      w_q <= m_q;
    end
  end

  assign bus.E_dst    = e_q.dst;
  assign bus.E_wen    = e_q.wen;
  assign bus.M_dst    = m_q.dst;
  assign bus.M_wen    = m_q.wen;
  assign bus.W_dst    = w_q.dst;
  assign bus.W_wen    = w_q.wen;
  assign bus.rf_we    = w_q.wen;
  assign bus.rf_waddr = w_q.dst;

`ifdef WB_COUNT_EN
  logic [31:0] wb_count_q;
  logic [31:0] bubble_count_q;

  // Count retired writes and inserted bubbles; both wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_count_q     <= '0;
      bubble_count_q <= '0;
    end else begin
      if (w_q.wen) wb_count_q     <= wb_count_q + 32'd1;
      if (bubble)  bubble_count_q <= bubble_count_q + 32'd1;
    end
  end

  assign bus.wb_count     = wb_count_q;
  assign bus.bubble_count = bubble_count_q;
`endif

endmodule
